// File: rtl/simd_result_writer_pkg.sv
// -----------------------------------------------------------------------------
// simd_result_writer_pkg
//   Shared definitions for the SIMD result write-back path: default geometry,
//   FSM state encoding and the beat select codes used on out_sel.
// -----------------------------------------------------------------------------
package simd_result_writer_pkg;

    // Default geometry of the write-back path.
    localparam int DEF_LANES  = 4;
    localparam int DEF_LANE_W = 32;
    localparam int DEF_ADDR_W = 6;

    // Write-back FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } wb_state_t;

    // out_sel codes: which half of a buffered vector a beat carries.
    localparam logic SEL_RESULT = 1'b0;
    localparam logic SEL_EXTRA  = 1'b1;

endpackage : simd_result_writer_pkg

// File: rtl/simd_wb_buffer.sv
// -----------------------------------------------------------------------------
// simd_wb_buffer
//   Vector buffer for the result writer: one synchronous write port and one
//   asynchronous read port. Each entry holds {result word, extra word}.
//   Contents are not reset.
//
// Ports
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data {result, extra}
//   raddr  in   read index
//   rdata  out  read data (combinational from raddr)
// -----------------------------------------------------------------------------
module simd_wb_buffer
    import simd_result_writer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = 2 * DEF_LANES * DEF_LANE_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : simd_wb_buffer

// File: rtl/simd_result_writer.sv
// -----------------------------------------------------------------------------
// simd_result_writer
//   Return path of the SIMD unit. After wb_start it collects wb_length result
//   vectors (one per res_valid strobe) into a buffer, then streams them to the
//   host as two beats per vector: result word (out_sel=0) then extra word
//   (out_sel=1), vector indices 0..length-1, with out_last on the final beat.
//   A one-cycle wb_done pulse follows the burst.
//
// Handshake (out_*): a beat transfers on a cycle where out_valid & out_ready.
//   Once out_valid is high it stays high, and out_data/out_sel/out_index/
//   out_last hold their values, until that transfer. out_ready is don't-care
//   while out_valid is low. out_valid is only ever high in DRAIN.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   wb_start     start pulse (IDLE only), wb_length latched with it
//   wb_length    number of vectors to collect
//   res_valid    all-lanes-done strobe, res_in/extra_in valid
//   res_in       lane results, lane0 in the top bits
//   extra_in     lane extra results, same packing
//   out_valid    beat valid
//   out_ready    host accepts beat
//   out_data     streamed word
//   out_sel      0 = result word, 1 = extra word
//   out_index    vector index of the beat
//   out_last     final beat of the burst
//   wb_busy      FSM not in IDLE
//   wb_done      one-cycle pulse after the final beat was accepted
//   wb_overflow  sticky: res_valid seen outside COLLECT; cleared by wb_start
//   dbg_state    current FSM state (debug observation)
// -----------------------------------------------------------------------------
module simd_result_writer
    import simd_result_writer_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wb_start,
    input  logic [ADDR_W-1:0]       wb_length,
    input  logic                    res_valid,
    input  logic [LANES*LANE_W-1:0] res_in,
    input  logic [LANES*LANE_W-1:0] extra_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic                    out_sel,
    output logic [ADDR_W-1:0]       out_index,
    output logic                    out_last,
    output logic                    wb_busy,
    output logic                    wb_done,
    output logic                    wb_overflow,
    output logic [1:0]              dbg_state
);

    localparam int W = LANES * LANE_W;
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    wb_state_t         state;
    wb_state_t         state_next;

    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] wr_cnt;

    logic              buf_we;
    logic [2*W-1:0]    rd_word;
    logic [ADDR_W-1:0] rd_addr;

    logic              beat_accept;
    logic              last_write;
    logic              final_accept;
    logic              load_beat;

    logic              nxt_sel;
    logic [W-1:0]      nxt_data;
    logic              nxt_last;

    assign beat_accept  = out_valid & out_ready;
    // Length never exceeds 2**ADDR_W-1, so wr_cnt+1 cannot wrap while collecting.
    assign last_write   = (state == ST_COLLECT) && res_valid && ((wr_cnt + ONE) == len_q);
    assign final_accept = (state == ST_DRAIN) && beat_accept && out_last;
    // Load the output register on the first DRAIN cycle (nothing presented
    // yet) and whenever a non-final beat is taken.
    assign load_beat    = (state == ST_DRAIN) && (!out_valid || (beat_accept && !out_last));

    assign buf_we    = (state == ST_COLLECT) && res_valid;
    assign wb_busy   = (state != ST_IDLE);
    assign dbg_state = state;

    simd_wb_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (2 * W)
    ) u_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_cnt),
        .wdata ({res_in, extra_in}),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (wb_start) begin
                    state_next = (wb_length == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (last_write) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (final_accept) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-beat selection. The beat after (i, result) is (i, extra); the beat
    // after (i, extra) is (i+1, result). With nothing presented the first beat
    // is (0, result).
    // -------------------------------------------------------------------------
    always_comb begin
        rd_addr = '0;
        nxt_sel = SEL_RESULT;
        if (out_valid) begin
            nxt_sel = ~out_sel;
            rd_addr = (out_sel == SEL_EXTRA) ? (out_index + ONE) : out_index;
        end
        nxt_data = (nxt_sel == SEL_EXTRA) ? rd_word[W-1:0] : rd_word[2*W-1:W];
        nxt_last = (nxt_sel == SEL_EXTRA) && (rd_addr == (len_q - ONE));
    end

    // -------------------------------------------------------------------------
    // Counters, output register and status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            wr_cnt      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sel     <= SEL_RESULT;
            out_index   <= '0;
            out_last    <= 1'b0;
            wb_done     <= 1'b0;
            wb_overflow <= 1'b0;
        end else begin
            // wb_done follows the DONE state by one cycle.
            wb_done <= (state == ST_DONE);

            if (state == ST_IDLE && wb_start) begin
                len_q       <= wb_length;
                wr_cnt      <= '0;
                wb_overflow <= 1'b0;
            end else if (state != ST_COLLECT && res_valid) begin
                wb_overflow <= 1'b1;
            end

            if (buf_we) begin
                wr_cnt <= wr_cnt + ONE;
            end

            if (final_accept) begin
                out_valid <= 1'b0;
                out_data  <= '0;
                out_sel   <= SEL_RESULT;
                out_index <= '0;
                out_last  <= 1'b0;
            end else if (load_beat) begin
                out_valid <= 1'b1;
                out_data  <= nxt_data;
                out_sel   <= nxt_sel;
                out_index <= rd_addr;
                out_last  <= nxt_last;
            end
        end
    end

endmodule : simd_result_writer

// File: tb/tb_simd_result_writer.sv
// -----------------------------------------------------------------------------
// tb_simd_result_writer
//   Self-checking bench for simd_result_writer. The scoreboard queue holds the
//   beats the host should see, each packed as {last, sel, index, data}, built
//   from the vectors the bench drives in.
// -----------------------------------------------------------------------------
module tb_simd_result_writer;

    localparam int W  = 128;
    localparam int A  = 6;
    localparam int BW = 1 + 1 + A + W;

    // DUT signals
    logic          clk;
    logic          reset;
    logic          wb_start;
    logic [A-1:0]  wb_length;
    logic          res_valid;
    logic [W-1:0]  res_in;
    logic [W-1:0]  extra_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_sel;
    logic [A-1:0]  out_index;
    logic          out_last;
    logic          wb_busy;
    logic          wb_done;
    logic          wb_overflow;
    logic [1:0]    dbg_state;

    // Scoreboard and bookkeeping
    logic [BW-1:0] exp_q[$];
    int            n_checks;
    int            n_fail;
    int            done_cnt;
    int            burst_beats;
    int            first_acc;
    int            last_acc;
    int            cyc;
    int            ready_mode;   // 0: always ready, 1: random, 2: pattern 1,0,0,1
    int            pat_idx;

    simd_result_writer dut (
        .clk         (clk),
        .reset       (reset),
        .wb_start    (wb_start),
        .wb_length   (wb_length),
        .res_valid   (res_valid),
        .res_in      (res_in),
        .extra_in    (extra_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sel     (out_sel),
        .out_index   (out_index),
        .out_last    (out_last),
        .wb_busy     (wb_busy),
        .wb_done     (wb_done),
        .wb_overflow (wb_overflow),
        .dbg_state   (dbg_state)
    );

    // -------------------------------------------------------------------------
    // Clock and cycle counter
    // -------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // -------------------------------------------------------------------------
    // Checking task
    // -------------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // out_ready driver
    // -------------------------------------------------------------------------
    initial begin
        out_ready = 1'b0;
        pat_idx   = 0;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 2) != 0);
            default: begin
                out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                pat_idx++;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output monitor: scoreboard compare on every transfer, hold check on stalls
    // -------------------------------------------------------------------------
    logic          stall_prev;
    logic [BW-1:0] held_beat;

    always @(negedge clk) begin
        logic [BW-1:0] cur_beat;
        logic [BW-1:0] exp_beat;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (wb_done) done_cnt++;
            cur_beat = {out_last, out_sel, out_index, out_data};
            if (stall_prev) begin
                check_eq("stall_valid_held", BW'(out_valid), BW'(1));
                check_eq("stall_beat_held", cur_beat, held_beat);
            end
            if (out_valid && out_ready) begin
                check_eq("beat_expected", BW'(exp_q.size() != 0), BW'(1));
                if (exp_q.size() != 0) begin
                    exp_beat = exp_q.pop_front();
                    check_eq("beat", cur_beat, exp_beat);
                end
                if (burst_beats == 0) first_acc = cyc;
                last_acc = cyc;
                burst_beats++;
            end
            stall_prev = out_valid && !out_ready;
            held_beat  = cur_beat;
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input int len);
        burst_beats = 0;
        wb_start    = 1'b1;
        wb_length   = A'(len);
        tick();
        wb_start    = 1'b0;
        wb_length   = '0;
    endtask

    // Drive one result vector and record the two beats it must produce.
    task automatic drive_vector(input logic [W-1:0] r, input logic [W-1:0] e,
                                input int idx, input bit last);
        res_valid = 1'b1;
        res_in    = r;
        extra_in  = e;
        exp_q.push_back({1'b0, 1'b0, A'(idx), r});
        exp_q.push_back({last, 1'b1, A'(idx), e});
        tick();
        res_valid = 1'b0;
        res_in    = '0;
        extra_in  = '0;
    endtask

    task automatic send_vectors(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) tick();
            end
            drive_vector({$urandom, $urandom, $urandom, $urandom},
                         {$urandom, $urandom, $urandom, $urandom}, i, (i == n - 1));
        end
    endtask

    // Pulse res_valid with junk that must not reach the stream.
    task automatic pulse_junk();
        res_valid = 1'b1;
        res_in    = {$urandom, $urandom, $urandom, $urandom};
        extra_in  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        res_valid = 1'b0;
        res_in    = '0;
        extra_in  = '0;
    endtask

    // Wait for one wb_done pulse (bounded), then confirm it was a single
    // one-cycle pulse and the scoreboard is drained.
    task automatic wait_done(input string tag, input int budget);
        int  d0;
        bit  timed_out;
        d0        = done_cnt;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
        end
        check_eq({tag, "_done_seen"}, BW'(timed_out), BW'(0));
        repeat (3) @(negedge clk);
        check_eq({tag, "_done_once"}, BW'(done_cnt - d0), BW'(1));
        check_eq({tag, "_queue_empty"}, BW'(exp_q.size()), BW'(0));
        check_eq({tag, "_idle_after"}, BW'(wb_busy), BW'(0));
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int  d0;
        bit  seen;

        n_checks    = 0;
        n_fail      = 0;
        done_cnt    = 0;
        burst_beats = 0;
        first_acc   = 0;
        last_acc    = 0;
        ready_mode  = 0;
        reset       = 1'b1;
        wb_start    = 1'b0;
        wb_length   = '0;
        res_valid   = 1'b0;
        res_in      = '0;
        extra_in    = '0;

        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_out_valid", BW'(out_valid), BW'(0));
        check_eq("rst_outputs", {out_last, out_sel, out_index, out_data}, '0);
        check_eq("rst_flags", BW'({wb_busy, wb_done, wb_overflow}), BW'(0));
        check_eq("rst_state", BW'(dbg_state), BW'(0));
        tick();
        reset = 1'b0;
        tick();

        // Test 1: fixed vectors, length 2, host always ready.
        ready_mode = 0;
        start_burst(2);
        drive_vector(128'h11111111_22222222_33333333_44444444, 128'h1, 0, 1'b0);
        drive_vector({4{32'hAAAAAAAA}}, 128'h2, 1, 1'b1);
        @(negedge clk);
        check_eq("t1_gap_cycle_valid", BW'(out_valid), BW'(0));
        check_eq("t1_gap_cycle_busy", BW'(wb_busy), BW'(1));
        @(negedge clk);
        check_eq("t1_first_beat_valid", BW'(out_valid), BW'(1));
        wait_done("t1", 50);
        check_eq("t1_beat_count", BW'(burst_beats), BW'(4));

        // Test 2: length 3, host ready pattern 1,0,0,1.
        pat_idx    = 0;
        ready_mode = 2;
        start_burst(3);
        send_vectors(3, 1'b0);
        wait_done("t2", 100);
        check_eq("t2_beat_count", BW'(burst_beats), BW'(6));
        ready_mode = 0;

        // Test 3: zero length goes straight to DONE.
        d0 = done_cnt;
        start_burst(0);
        @(negedge clk);
        check_eq("t3_busy_first", BW'(wb_busy), BW'(1));
        check_eq("t3_done_early", BW'(wb_done), BW'(0));
        check_eq("t3_no_valid", BW'(out_valid), BW'(0));
        @(negedge clk);
        check_eq("t3_busy_second", BW'(wb_busy), BW'(0));
        check_eq("t3_done_pulse", BW'(wb_done), BW'(1));
        @(negedge clk);
        check_eq("t3_done_cleared", BW'(wb_done), BW'(0));
        check_eq("t3_done_count", BW'(done_cnt - d0), BW'(1));
        check_eq("t3_beat_count", BW'(burst_beats), BW'(0));

        // Test 4: res_valid outside COLLECT is dropped and sets wb_overflow.
        pulse_junk();
        @(negedge clk);
        check_eq("t4_ovf_idle", BW'(wb_overflow), BW'(1));
        ready_mode = 1;
        start_burst(3);
        @(negedge clk);
        check_eq("t4_ovf_cleared", BW'(wb_overflow), BW'(0));
        send_vectors(3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t4_drain_reached", BW'(seen), BW'(1));
        tick();
        pulse_junk();
        @(negedge clk);
        check_eq("t4_ovf_drain", BW'(wb_overflow), BW'(1));
        wait_done("t4", 100);
        check_eq("t4_ovf_sticky", BW'(wb_overflow), BW'(1));
        ready_mode = 0;

        // Test 5: reset after the second beat of a length-4 burst.
        start_burst(4);
        @(negedge clk);
        check_eq("t5_ovf_cleared", BW'(wb_overflow), BW'(0));
        send_vectors(4, 1'b0);
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            if (burst_beats >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("t5_two_beats", BW'(seen), BW'(1));
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("t5_rst_valid", BW'(out_valid), BW'(0));
        check_eq("t5_rst_outputs", {out_last, out_sel, out_index, out_data}, '0);
        check_eq("t5_rst_flags", BW'({wb_busy, wb_done, wb_overflow}), BW'(0));
        check_eq("t5_rst_state", BW'(dbg_state), BW'(0));
        repeat (4) @(negedge clk);
        check_eq("t5_no_done", BW'(done_cnt - d0), BW'(0));
        tick();
        start_burst(1);
        send_vectors(1, 1'b0);
        wait_done("t5_new", 50);
        check_eq("t5_new_beats", BW'(burst_beats), BW'(2));

        // Test 6: maximum length, back-to-back input and output.
        start_burst(63);
        send_vectors(63, 1'b0);
        @(negedge clk);
        check_eq("t6_gap_cycle_valid", BW'(out_valid), BW'(0));
        wait_done("t6", 400);
        check_eq("t6_beat_count", BW'(burst_beats), BW'(126));
        check_eq("t6_consecutive", BW'(last_acc - first_acc), BW'(125));

        // Randomized bursts with random gaps and random host backpressure.
        ready_mode = 1;
        for (int k = 0; k < 6; k++) begin
            int len;
            len = $urandom_range(1, 12);
            start_burst(len);
            send_vectors(len, 1'b1);
            wait_done("rnd", 200);
            check_eq("rnd_beat_count", BW'(burst_beats), BW'(2 * len));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule : tb_simd_result_writer
